// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state enums and default operand width for the ALU share arbiter
package alu_pkg;
   localparam int W = 4;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_XOR = 2'b11} op_e;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} st_e;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: per-requester valid/ready operation bus plus the result handshake
interface alu_share_arbiter_if #(parameter int W = alu_pkg::W, parameter int N_REQ = 2);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0][1:0]   req_op;
   logic [N_REQ-1:0][W-1:0] req_a;
   logic [N_REQ-1:0][W-1:0] req_b;
   logic                    resp_valid;
   logic                    resp_ready;
   logic                    resp_id;
   logic [W:0]              resp_result;
   modport master (output req_valid, req_op, req_a, req_b, resp_ready,
                   input  req_ready, resp_valid, resp_id, resp_result);
   modport slave  (input  req_valid, req_op, req_a, req_b, resp_ready,
                   output req_ready, resp_valid, resp_id, resp_result);
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational add/sub/and/xor with a W+1-bit result (carry or borrow in the top bit)
module alu_core import alu_pkg::*; #(parameter int W = alu_pkg::W) (
   input  op_e          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W:0]   result
);
   always_comb begin
      result = op == OP_ADD ? {1'b0, a} + {1'b0, b} :
               op == OP_SUB ? {1'b0, a} - {1'b0, b} :
               op == OP_AND ? {1'b0, a & b} : {1'b0, a ^ b};
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin grant of one shared ALU to two requesters, IDLE->EXEC->RESP sequencing.
// Optional saturating per-requester grant counters with ALU_ARB_STATS_EN.
module alu_share_arbiter import alu_pkg::*; #(
   parameter int W     = alu_pkg::W,
   parameter int N_REQ = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_share_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [7:0]          grant_cnt0,
   output logic [7:0]          grant_cnt1
`endif
);
   st_e              st, nxt;
   logic             last_grant, g, hs, id_q;
   logic [N_REQ-1:0] gnt;
   op_e              op_q;
   logic [W-1:0]     a_q, b_q;
   logic [W:0]       res_q, alu_res;

   alu_core #(.W(W)) u_core (.op(op_q), .a(a_q), .b(b_q), .result(alu_res));

   // rst_n gates the grant so req_ready is low while reset is held
   always_comb begin
      g   = &bus.req_valid ? ~last_grant : bus.req_valid[1];
      gnt = (st == ST_IDLE && rst_n && |bus.req_valid) ? N_REQ'(1) << g : '0;
      hs  = |(bus.req_valid & gnt);
      nxt = (st == ST_IDLE && hs)             ? ST_EXEC :
            st == ST_EXEC                     ? ST_RESP :
            (st == ST_RESP && bus.resp_ready) ? ST_IDLE : st;
   end

   assign bus.req_ready   = gnt;
   assign bus.resp_valid  = st == ST_RESP;
   assign bus.resp_id     = id_q;
   assign bus.resp_result = res_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= ST_IDLE;
      else        st <= nxt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         last_grant <= 1'b1;
         id_q       <= 1'b0;
         op_q       <= OP_ADD;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
      end else begin
         if (hs) begin
            last_grant <= g;
            id_q       <= g;
            op_q       <= op_e'(bus.req_op[g]);
            a_q        <= bus.req_a[g];
            b_q        <= bus.req_b[g];
         end
         if (st == ST_EXEC) res_q <= alu_res;
      end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (hs) begin
         if (!g && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'd1;
         if (g && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'd1;
      end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vector table plus contention, backpressure, reset and counter sequences
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.W(4), .N_REQ(2)) bus ();
`ifdef ALU_ARB_STATS_EN
   logic [7:0] grant_cnt0, grant_cnt1;
`endif

   alu_share_arbiter #(.W(4), .N_REQ(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef ALU_ARB_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
   );

   typedef struct {
      logic       id;
      op_e        op;
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] res;
   } vec_t;

   vec_t vecs[8];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // entered #1 after a rising edge with the DUT in IDLE
   task automatic do_vec(input vec_t v);
      bus.req_valid       = '0;
      bus.req_valid[v.id] = 1'b1;
      bus.req_op[v.id]    = v.op;
      bus.req_a[v.id]     = v.a;
      bus.req_b[v.id]     = v.b;
      @(negedge clk); chk("vec_grant", 32'(bus.req_ready), 32'(2'b01 << v.id));
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk); chk("vec_exec_valid", 32'(bus.resp_valid), 0);
      @(posedge clk);
      @(negedge clk);
      chk("vec_resp_valid", 32'(bus.resp_valid), 1);
      chk("vec_resp_id", 32'(bus.resp_id), 32'(v.id));
      chk("vec_result", 32'(bus.resp_result), 32'(v.res));
      bus.resp_ready = 1'b1;
      @(posedge clk); #1 bus.resp_ready = 1'b0;
   endtask

   initial begin
      int ng, nr;
      vecs[0] = '{1'b0, OP_ADD, 4'hD, 4'hC, 5'h19};
      vecs[1] = '{1'b1, OP_SUB, 4'h3, 4'h5, 5'h1E};
      vecs[2] = '{1'b0, OP_AND, 4'hF, 4'h8, 5'h08};
      vecs[3] = '{1'b1, OP_XOR, 4'hF, 4'h5, 5'h0A};
      vecs[4] = '{1'b1, OP_ADD, 4'hF, 4'hF, 5'h1E};
      vecs[5] = '{1'b0, OP_SUB, 4'h5, 4'h3, 5'h02};
      vecs[6] = '{1'b0, OP_SUB, 4'h0, 4'h1, 5'h1F};
      vecs[7] = '{1'b1, OP_AND, 4'hA, 4'h5, 5'h00};

      bus.req_valid = 2'b11;
      bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
      bus.resp_ready = 1'b0;
      #2;
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_resp_id", 32'(bus.resp_id), 0);
      chk("rst_resp_result", 32'(bus.resp_result), 0);
      repeat (2) @(posedge clk);
      #1 bus.req_valid = '0; rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) do_vec(vecs[i]);

      // both requesters valid continuously from a fresh reset
      rst_n = 1'b0; #1 rst_n = 1'b1;
      bus.req_op[0] = OP_ADD; bus.req_a[0] = 4'h1; bus.req_b[0] = 4'h2;
      bus.req_op[1] = OP_XOR; bus.req_a[1] = 4'hA; bus.req_b[1] = 4'h5;
      bus.req_valid = 2'b11; bus.resp_ready = 1'b1;
      ng = 0; nr = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.req_ready != 2'b00) begin
            chk("rr_grant", 32'(bus.req_ready), (ng % 2 == 0) ? 1 : 2);
            ng++;
         end
         if (bus.resp_valid) begin
            chk("rr_resp_id", 32'(bus.resp_id), 32'(nr % 2));
            chk("rr_result", 32'(bus.resp_result), (nr % 2 == 0) ? 32'h03 : 32'h0F);
            nr++;
         end
      end
      chk("rr_grant_count", 32'(ng), 4);
      chk("rr_resp_count", 32'(nr), 4);
      @(posedge clk); #1 bus.req_valid = '0; bus.resp_ready = 1'b0;

      // backpressure: requester 1 waits while the response is held
      bus.req_op[0] = OP_ADD; bus.req_a[0] = 4'h7; bus.req_b[0] = 4'h1;
      bus.req_valid = 2'b01;
      @(negedge clk); chk("bp_grant0", 32'(bus.req_ready), 1);
      @(posedge clk); #1;
      bus.req_op[1] = OP_SUB; bus.req_a[1] = 4'h9; bus.req_b[1] = 4'h2;
      bus.req_valid = 2'b10;
      @(negedge clk); chk("bp_exec_ready", 32'(bus.req_ready), 0);
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(bus.resp_valid), 1);
         chk("bp_hold_id", 32'(bus.resp_id), 0);
         chk("bp_hold_result", 32'(bus.resp_result), 32'h08);
         chk("bp_hold_ready", 32'(bus.req_ready), 0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1 bus.resp_ready = 1'b0;
      @(negedge clk); chk("bp_next_grant", 32'(bus.req_ready), 2);
      @(posedge clk); #1 bus.req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_second_id", 32'(bus.resp_id), 1);
      chk("bp_second_result", 32'(bus.resp_result), 32'h07);
      bus.resp_ready = 1'b1;
      @(posedge clk); #1 bus.resp_ready = 1'b0;

      // reset while in EXEC discards the operation and restores last_grant
      bus.req_op[0] = OP_ADD; bus.req_a[0] = 4'h2; bus.req_b[0] = 4'h2;
      bus.req_valid = 2'b01;
      @(posedge clk); #1;
      bus.req_valid = 2'b11; rst_n = 1'b0;
      #1;
      chk("rst_exec_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_exec_req_ready", 32'(bus.req_ready), 0);
      @(posedge clk); @(posedge clk); #1;
      chk("rst_hold_resp_valid", 32'(bus.resp_valid), 0);
      rst_n = 1'b1; #1;
      chk("rst_release_grant", 32'(bus.req_ready), 1);
      @(negedge clk); chk("rst_no_replay", 32'(bus.resp_valid), 0);
      @(posedge clk); #1 bus.req_valid = '0; bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_after_valid", 32'(bus.resp_valid), 1);
      chk("rst_after_id", 32'(bus.resp_id), 0);
      chk("rst_after_result", 32'(bus.resp_result), 32'h04);
      @(posedge clk); #1 bus.resp_ready = 1'b0;

`ifdef ALU_ARB_STATS_EN
      rst_n = 1'b0; #1 rst_n = 1'b1;
      chk("cnt0_reset", 32'(grant_cnt0), 0);
      chk("cnt1_reset", 32'(grant_cnt1), 0);
      bus.req_valid = 2'b01; bus.resp_ready = 1'b1;
      repeat (300) @(posedge clk);
      #1 chk("cnt0_100", 32'(grant_cnt0), 100);
      repeat (600) @(posedge clk);
      #1 bus.req_valid = '0;
      chk("cnt0_sat", 32'(grant_cnt0), 32'hFF);
      chk("cnt1_zero", 32'(grant_cnt1), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
